// File: rtl/hl_eth_pkg.sv
// ---------------------------------------------------------------------------
// hl_eth_pkg
// Shared definitions for the Hermes Lite Ethernet MII path (receive
// deframer and transmit framer).
//
// Contents:
//   CRC32_POLY     reflected CRC-32 polynomial, processed LSB first
//   CRC32_INIT     CRC register value at the start of each frame
//   CRC32_RESIDUE  register value left after running the CRC over a frame
//                  whose FCS is correct (FCS bytes included)
//   PREAMBLE_NIB   preamble nibble as seen on the 4-bit MII bus
//   SFD_NIB        start-of-frame-delimiter nibble
//   LEN_CNT_W      width of the saturating byte-length counter
//   rxState_e      receive deframer state encoding
// ---------------------------------------------------------------------------
package hl_eth_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

   localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
   localparam logic [3:0]  SFD_NIB       = 4'hD;

   localparam int          LEN_CNT_W     = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_END,
      ST_DROP
   } rxState_e;

endpackage

// File: rtl/crc32_byte.sv
// ---------------------------------------------------------------------------
// crc32_byte
// Purely combinational single-byte step of the reflected Ethernet CRC-32.
// Shared by the receive deframer and the transmit framer.
//
// Ports:
//   crc_i   [31:0] in   current CRC register
//   data_i  [7:0]  in   byte to fold in (bit 0 is processed first)
//   crc_o   [31:0] out  CRC register after the byte
// ---------------------------------------------------------------------------
module crc32_byte
   import hl_eth_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] crcWork;

   // The byte is XORed into the low end of the register, then eight
   // shift-right steps fold in the reflected polynomial whenever the bit
   // being shifted out is a one. Unrolled by synthesis into an XOR network.
   always_comb begin
      crcWork = crc_i ^ {24'd0, data_i};
      for (int i = 0; i < 8; i++) begin
         if (crcWork[0]) begin
            crcWork = (crcWork >> 1) ^ CRC32_POLY;
         end else begin
            crcWork = crcWork >> 1;
         end
      end
      crc_o = crcWork;
   end

endmodule

// File: rtl/mii_rx_deframer.sv
// ---------------------------------------------------------------------------
// mii_rx_deframer
// Receive-side MII deframer. Finds preamble/SFD in the PHY nibble stream,
// assembles bytes (low nibble first), hides the 4-byte FCS behind a
// 4-entry delay line, checks CRC-32, length and nibble alignment, and
// delivers DA..last-data-byte to the packet parser, followed by one
// end-of-frame strobe carrying the good/bad verdict.
//
// Parameters:
//   MIN_LEN  minimum frame length in bytes, DA through FCS
//   MAX_LEN  maximum frame length in bytes, DA through FCS
//
// Ports:
//   clk        in        PHY_RX_CLOCK, rising edge
//   rst        in        asynchronous active-high reset
//   rx_nib     in  [3:0] MII receive nibble (PHY_RX)
//   rx_dv      in        MII receive data valid (RX_DV)
//   rx_data    out [7:0] payload byte, qualified by rx_valid
//   rx_valid   out       one-cycle strobe per payload byte
//   rx_sop     out       with rx_valid on the first payload byte
//   rx_eop     out       one-cycle end-of-frame strobe, no data
//   rx_good    out       verdict with rx_eop: no error of any kind
//   crc_err    out       with rx_eop: CRC residue wrong
//   len_err    out       with rx_eop: length out of MIN_LEN..MAX_LEN
//   align_err  out       with rx_eop: frame ended on an odd nibble
//   frame_cnt  out [15:0] wrapping count of good frames
// ---------------------------------------------------------------------------
module mii_rx_deframer
   import hl_eth_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  rx_nib,
   input  logic        rx_dv,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sop,
   output logic        rx_eop,
   output logic        rx_good,
   output logic        crc_err,
   output logic        len_err,
   output logic        align_err,
   output logic [15:0] frame_cnt
);

   localparam logic [LEN_CNT_W-1:0] MIN_LEN_C = LEN_CNT_W'(MIN_LEN);
   localparam logic [LEN_CNT_W-1:0] MAX_LEN_C = LEN_CNT_W'(MAX_LEN);

   rxState_e               state_q, state_d;

   logic                   armed_q, armed_d;
   logic                   phase_q, phase_d;
   logic [3:0]             lowNib_q, lowNib_d;
   logic [31:0]            crc_q, crc_d;
   logic [LEN_CNT_W-1:0]   lenCnt_q, lenCnt_d;
   logic [3:0][7:0]        delay_q, delay_d;
   logic [2:0]             fill_q, fill_d;
   logic                   sopPending_q, sopPending_d;

   logic [7:0]             rxData_q, rxData_d;
   logic                   rxValid_q, rxValid_d;
   logic                   rxSop_q, rxSop_d;
   logic                   rxEop_q, rxEop_d;
   logic                   rxGood_q, rxGood_d;
   logic                   crcErr_q, crcErr_d;
   logic                   lenErr_q, lenErr_d;
   logic                   alignErr_q, alignErr_d;
   logic [15:0]            frameCnt_q, frameCnt_d;

   logic                   sfdSeen;
   logic                   nibTake;
   logic                   frameEnd;
   logic                   byteDone;
   logic [7:0]             rxByte;
   logic [31:0]            crcNext;
   logic                   crcBad;
   logic                   lenBad;
   logic                   alignBad;
   logic                   frameGood;

   // The byte completes on the high nibble, which is the nibble on the bus
   // in the same cycle as the completion.
   assign rxByte   = {rx_nib, lowNib_q};
   assign byteDone = nibTake & phase_q;

   crc32_byte u_crc32_byte (
      .crc_i  (crc_q),
      .data_i (rxByte),
      .crc_o  (crcNext)
   );

   // Verdict terms, evaluated on the cycle that sees rx_dv fall in DATA.
   // A dangling low nibble (phase_q set) was never folded into the CRC or
   // the length, so those two checks see only whole bytes.
   assign crcBad    = (crc_q != CRC32_RESIDUE);
   assign lenBad    = (lenCnt_q < MIN_LEN_C) || (lenCnt_q > MAX_LEN_C);
   assign alignBad  = phase_q;
   assign frameGood = ~(crcBad | lenBad | alignBad);

   // Next-state logic for the framing FSM. Besides the next state it
   // produces three single-cycle control strobes for the datapath: SFD
   // detected, payload nibble accepted, and frame ended. IDLE refuses to
   // start a frame until rx_dv has been seen low since reset, so a reset
   // landing mid-frame cannot lock onto a 0x5 payload nibble.
   always_comb begin
      state_d  = state_q;
      sfdSeen  = 1'b0;
      nibTake  = 1'b0;
      frameEnd = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_dv) begin
               if (armed_q && (rx_nib == PREAMBLE_NIB)) begin
                  state_d = ST_PREAMBLE;
               end else begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_PREAMBLE: begin
            if (!rx_dv) begin
               state_d = ST_IDLE;
            end else if (rx_nib == SFD_NIB) begin
               state_d = ST_DATA;
               sfdSeen = 1'b1;
            end else if (rx_nib != PREAMBLE_NIB) begin
               state_d = ST_DROP;
            end
         end
         ST_DATA: begin
            if (!rx_dv) begin
               state_d  = ST_END;
               frameEnd = 1'b1;
            end else begin
               nibTake = 1'b1;
            end
         end
         ST_END: begin
            state_d = ST_IDLE;
         end
         ST_DROP: begin
            if (!rx_dv) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath next-state. Strobe outputs default low every cycle so each
   // one is a single-cycle pulse. The delay line holds the newest byte in
   // entry 0 and the oldest in entry 3; once four bytes are buffered every
   // new byte pushes the oldest one out to rx_data, which keeps the last
   // four bytes of the frame (the FCS) from ever being emitted.
   always_comb begin
      armed_d      = armed_q | ~rx_dv;
      phase_d      = phase_q;
      lowNib_d     = lowNib_q;
      crc_d        = crc_q;
      lenCnt_d     = lenCnt_q;
      delay_d      = delay_q;
      fill_d       = fill_q;
      sopPending_d = sopPending_q;
      rxData_d     = rxData_q;
      rxValid_d    = 1'b0;
      rxSop_d      = 1'b0;
      rxEop_d      = 1'b0;
      rxGood_d     = 1'b0;
      crcErr_d     = 1'b0;
      lenErr_d     = 1'b0;
      alignErr_d   = 1'b0;
      frameCnt_d   = frameCnt_q;

      if (sfdSeen) begin
         phase_d      = 1'b0;
         crc_d        = CRC32_INIT;
         lenCnt_d     = '0;
         delay_d      = '0;
         fill_d       = 3'd0;
         sopPending_d = 1'b1;
      end

      if (nibTake && !phase_q) begin
         lowNib_d = rx_nib;
         phase_d  = 1'b1;
      end

      if (byteDone) begin
         phase_d = 1'b0;
         crc_d   = crcNext;
         if (lenCnt_q != '1) begin
            lenCnt_d = lenCnt_q + 1'b1;
         end
         if (fill_q == 3'd4) begin
            rxValid_d    = 1'b1;
            rxData_d     = delay_q[3];
            rxSop_d      = sopPending_q;
            sopPending_d = 1'b0;
         end else begin
            fill_d = fill_q + 3'd1;
         end
         delay_d = {delay_q[2:0], rxByte};
      end

      if (frameEnd) begin
         rxEop_d    = 1'b1;
         rxGood_d   = frameGood;
         crcErr_d   = crcBad;
         lenErr_d   = lenBad;
         alignErr_d = alignBad;
         phase_d    = 1'b0;
         if (frameGood) begin
            frameCnt_d = frameCnt_q + 16'd1;
         end
      end
   end

   // State and datapath registers. Reset clears everything, including the
   // armed flag, so any frame in flight when reset hits is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         armed_q      <= 1'b0;
         phase_q      <= 1'b0;
         lowNib_q     <= 4'd0;
         crc_q        <= CRC32_INIT;
         lenCnt_q     <= '0;
         delay_q      <= '0;
         fill_q       <= 3'd0;
         sopPending_q <= 1'b0;
         rxData_q     <= 8'd0;
         rxValid_q    <= 1'b0;
         rxSop_q      <= 1'b0;
         rxEop_q      <= 1'b0;
         rxGood_q     <= 1'b0;
         crcErr_q     <= 1'b0;
         lenErr_q     <= 1'b0;
         alignErr_q   <= 1'b0;
         frameCnt_q   <= 16'd0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         phase_q      <= phase_d;
         lowNib_q     <= lowNib_d;
         crc_q        <= crc_d;
         lenCnt_q     <= lenCnt_d;
         delay_q      <= delay_d;
         fill_q       <= fill_d;
         sopPending_q <= sopPending_d;
         rxData_q     <= rxData_d;
         rxValid_q    <= rxValid_d;
         rxSop_q      <= rxSop_d;
         rxEop_q      <= rxEop_d;
         rxGood_q     <= rxGood_d;
         crcErr_q     <= crcErr_d;
         lenErr_q     <= lenErr_d;
         alignErr_q   <= alignErr_d;
         frameCnt_q   <= frameCnt_d;
      end
   end

   assign rx_data   = rxData_q;
   assign rx_valid  = rxValid_q;
   assign rx_sop    = rxSop_q;
   assign rx_eop    = rxEop_q;
   assign rx_good   = rxGood_q;
   assign crc_err   = crcErr_q;
   assign len_err   = lenErr_q;
   assign align_err = alignErr_q;
   assign frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_mii_rx_deframer
// Directed frames are driven nibble by nibble; for each frame the expected
// byte strobes and end-of-frame verdict are queued, and an independent
// monitor pops and compares them whenever the DUT strobes an output.
// ---------------------------------------------------------------------------
module tb_mii_rx_deframer;

   logic        clk;
   logic        rst;
   logic [3:0]  rx_nib;
   logic        rx_dv;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sop;
   logic        rx_eop;
   logic        rx_good;
   logic        crc_err;
   logic        len_err;
   logic        align_err;
   logic [15:0] frame_cnt;

   typedef struct {
      bit         isEop;
      logic [7:0] data;
      bit         sop;
      bit         good;
      bit         crcE;
      bit         lenE;
      bit         alignE;
   } exp_t;

   exp_t       expQ[$];
   logic [7:0] txFrame[$];
   int         checkCnt = 0;
   int         passCnt  = 0;

   mii_rx_deframer #(
      .MIN_LEN (64),
      .MAX_LEN (1518)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_nib    (rx_nib),
      .rx_dv     (rx_dv),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_sop    (rx_sop),
      .rx_eop    (rx_eop),
      .rx_good   (rx_good),
      .crc_err   (crc_err),
      .len_err   (len_err),
      .align_err (align_err),
      .frame_cnt (frame_cnt)
   );

   // 100 MHz-style free-running receive clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point shared by the stimulus and the monitor
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCnt++;
      if (actual === expected) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Bitwise reflected CRC-32 used to build correct FCS fields
   function automatic logic [31:0] crcStep(input logic [31:0] c,
                                           input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   // Payload bytes count up from 0 (mod 256); FCS appended LSB first;
   // an optional payload byte is then corrupted to 0xFF.
   task automatic buildFrame(input int nPayload, input int flipIdx);
      logic [31:0] c;
      logic [31:0] fcs;
      txFrame.delete();
      c = 32'hFFFFFFFF;
      for (int i = 0; i < nPayload; i++) begin
         txFrame.push_back(8'(i));
         c = crcStep(c, 8'(i));
      end
      fcs = ~c;
      txFrame.push_back(fcs[7:0]);
      txFrame.push_back(fcs[15:8]);
      txFrame.push_back(fcs[23:16]);
      txFrame.push_back(fcs[31:24]);
      if (flipIdx >= 0) txFrame[flipIdx] = 8'hFF;
   endtask

   task automatic expectBytes(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = '{isEop: 1'b0, data: txFrame[i], sop: (i == 0), good: 1'b0,
               crcE: 1'b0, lenE: 1'b0, alignE: 1'b0};
         expQ.push_back(e);
      end
   endtask

   task automatic expectEop(input bit good, input bit crcE, input bit lenE,
                            input bit alignE);
      exp_t e;
      e = '{isEop: 1'b1, data: 8'h00, sop: 1'b0, good: good,
            crcE: crcE, lenE: lenE, alignE: alignE};
      expQ.push_back(e);
   endtask

   task automatic driveNib(input logic dv, input logic [3:0] nib);
      @(posedge clk);
      #1;
      rx_dv  = dv;
      rx_nib = nib;
   endtask

   // Sends txFrame with preamble/SFD, optional trailing odd nibble, an
   // optional reset pulse right after byte rstAtByte's low nibble has been
   // sampled, and gap idle cycles afterwards.
   task automatic applyStimulus(input int preLen, input bit extraNib,
                                input int rstAtByte, input int gap);
      for (int i = 0; i < preLen; i++) driveNib(1'b1, 4'h5);
      driveNib(1'b1, 4'hD);
      for (int i = 0; i < txFrame.size(); i++) begin
         driveNib(1'b1, txFrame[i][3:0]);
         driveNib(1'b1, txFrame[i][7:4]);
         if (i == rstAtByte) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput("rstValid", 32'(rx_valid), 32'd0);
            checkOutput("rstEop", 32'(rx_eop), 32'd0);
            checkOutput("rstData", 32'(rx_data), 32'd0);
            checkOutput("rstFrameCnt", 32'(frame_cnt), 32'd0);
         end
         if (i == rstAtByte + 1) rst = 1'b0;
      end
      if (extraNib) driveNib(1'b1, 4'hA);
      for (int i = 0; i < gap; i++) driveNib(1'b0, 4'h0);
   endtask

   // Monitor: every output strobe must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (rx_valid || rx_eop) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedStrobe", {rx_valid, rx_eop, rx_data}, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("strobeKind", {30'd0, rx_valid, rx_eop},
                           e.isEop ? 32'd1 : 32'd2);
               if (!e.isEop) begin
                  checkOutput("rxData", 32'(rx_data), 32'(e.data));
                  checkOutput("rxSop", 32'(rx_sop), 32'(e.sop));
               end else begin
                  checkOutput("eopVerdict",
                              {28'd0, rx_good, crc_err, len_err, align_err},
                              {28'd0, e.good, e.crcE, e.lenE, e.alignE});
               end
            end
         end
         if (!rx_eop && (rx_good || crc_err || len_err || align_err)) begin
            checkOutput("strayVerdict", {rx_good, crc_err, len_err, align_err}, 32'd0);
         end
         if (rx_sop && !rx_valid) begin
            checkOutput("straySop", 32'd1, 32'd0);
         end
      end
   end

   initial begin
      rst    = 1'b1;
      rx_dv  = 1'b0;
      rx_nib = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("resetValid", 32'(rx_valid), 32'd0);
      checkOutput("resetEop", 32'(rx_eop), 32'd0);
      checkOutput("resetData", 32'(rx_data), 32'd0);
      checkOutput("resetFlags", {rx_sop, rx_good, crc_err, len_err, align_err}, 32'd0);
      checkOutput("resetFrameCnt", 32'(frame_cnt), 32'd0);
      repeat (2) driveNib(1'b0, 4'h0);

      $display("[TB] good 64-byte frame");
      buildFrame(60, -1);
      expectBytes(60);
      expectEop(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(15, 1'b0, -1, 4);
      checkOutput("frameCntGood", 32'(frame_cnt), 32'd1);

      $display("[TB] corrupted payload byte 10");
      buildFrame(60, 10);
      expectBytes(60);
      expectEop(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(15, 1'b0, -1, 4);
      checkOutput("frameCntCrcBad", 32'(frame_cnt), 32'd1);

      $display("[TB] 40-byte runt");
      buildFrame(36, -1);
      expectBytes(36);
      expectEop(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(15, 1'b0, -1, 4);

      $display("[TB] 1519-byte giant");
      buildFrame(1515, -1);
      expectBytes(1515);
      expectEop(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(15, 1'b0, -1, 4);
      checkOutput("frameCntLenBad", 32'(frame_cnt), 32'd1);

      $display("[TB] trailing odd nibble");
      buildFrame(60, -1);
      expectBytes(60);
      expectEop(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(15, 1'b1, -1, 4);
      checkOutput("frameCntAlign", 32'(frame_cnt), 32'd1);

      $display("[TB] bad preamble then back-to-back good frames");
      driveNib(1'b1, 4'h5);
      driveNib(1'b1, 4'h5);
      driveNib(1'b1, 4'h3);
      driveNib(1'b1, 4'h5);
      driveNib(1'b1, 4'hD);
      for (int i = 0; i < 20; i++) driveNib(1'b1, 4'(i));
      driveNib(1'b0, 4'h0);
      buildFrame(60, -1);
      expectBytes(60);
      expectEop(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(15, 1'b0, -1, 1);
      expectBytes(60);
      expectEop(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(15, 1'b0, -1, 4);
      checkOutput("frameCntAfterDrop", 32'(frame_cnt), 32'd3);

      $display("[TB] reset during payload byte 30");
      buildFrame(60, -1);
      expectBytes(26);
      applyStimulus(15, 1'b0, 30, 4);
      checkOutput("frameCntAfterRst", 32'(frame_cnt), 32'd0);
      expectBytes(60);
      expectEop(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(15, 1'b0, -1, 4);
      checkOutput("frameCntRecovered", 32'(frame_cnt), 32'd1);

      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
